// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder.
// Holds stage-count derivation, parameter legality and group G/P.
package cla_pkg;

    localparam int MAX_GROUP = 8;

    function automatic int cla_nstg(input int width, input int group);
        return width / group;
    endfunction

    function automatic bit cla_legal(input int width, input int group);
        bit grp_ok;
        grp_ok = (group == 2) || (group == 4) || (group == 8);
        return grp_ok && (width > 0) && ((width % group) == 0);
    endfunction

    // Span generate/propagate over bits [n-1:0], written as a
    // flat sum of products: G = OR_i g[i] & p[n-1:i+1], P = AND p.
    function automatic logic [1:0] cla_gp(
        input logic [MAX_GROUP-1:0] g,
        input logic [MAX_GROUP-1:0] p,
        input int                   n
    );
        logic gg;
        logic pp;
        logic term;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < MAX_GROUP; i++) begin
            if (i < n) begin
                term = g[i];
                for (int j = i + 1; j < MAX_GROUP; j++) begin
                    if (j < n) term = term & p[j];
                end
                gg = gg | term;
                pp = pp & p[i];
            end
        end
        return {gg, pp};
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice; every carry comes from G/P terms.
// Ports: a, b, cin in; s (group sum), cout (group carry-out) out.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout
);

    logic [MAX_GROUP-1:0] g_ext;
    logic [MAX_GROUP-1:0] p_ext;
    logic [GROUP:0]       c;
    logic [1:0]           gp;

    always_comb begin
        g_ext = '0;
        p_ext = '0;
        g_ext[GROUP-1:0] = a & b;
        p_ext[GROUP-1:0] = a ^ b;
        c  = '0;
        gp = '0;
        // c[i] depends only on G/P of bits below i and cin.
        for (int i = 0; i <= GROUP; i++) begin
            gp   = cla_gp(g_ext, p_ext, i);
            c[i] = gp[1] | (gp[0] & cin);
        end
    end

    assign s    = p_ext[GROUP-1:0] ^ c[GROUP-1:0];
    assign cout = c[GROUP];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined add/subtract: one lookahead group resolved per stage.
// Ports: clk, rst, in_valid/in_ready, a_in, b_in, c_in, sub in;
//        out_valid/out_ready, sum, co, ovf out.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NSTG = cla_nstg(WIDTH, GROUP);

    if (!cla_legal(WIDTH, GROUP)) begin : g_bad_param
        $error("pipe_cla_adder: WIDTH must be a multiple of GROUP in {2,4,8}");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Whole pipe moves in lockstep; bubbles are not squeezed out.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Subtract as A + ~B + ~c_in, so c_in acts as borrow-in.
    assign b_eff = b_in ^ {WIDTH{sub}};
    assign c_eff = c_in ^ sub;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [WIDTH-1:0] s_nxt;
        logic [GROUP-1:0] g_sum;
        logic             g_cout;

        // Operands ride along whole; each stage owns only its slice.
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_head
            assign a_src = a_in;
            assign b_src = b_eff;
            assign s_src = '0;
            assign c_src = c_eff;
            assign v_src = in_valid;
        end else begin : g_body
            assign a_src = g_stg[k-1].a_q;
            assign b_src = g_stg[k-1].b_q;
            assign s_src = g_stg[k-1].s_q;
            assign c_src = g_stg[k-1].c_q;
            assign v_src = g_stg[k-1].v_q;
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a    (a_src[k*GROUP +: GROUP]),
            .b    (b_src[k*GROUP +: GROUP]),
            .cin  (c_src),
            .s    (g_sum),
            .cout (g_cout)
        );

        always_comb begin
            s_nxt = s_src;
            s_nxt[k*GROUP +: GROUP] = g_sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_src;
                a_q <= a_src;
                b_q <= b_src;
                s_q <= s_nxt;
                c_q <= g_cout;
            end
        end
    end

    logic c_msb;

    // Carry into the MSB recovered from its sum bit and operands.
    assign c_msb = g_stg[NSTG-1].s_q[WIDTH-1]
                 ^ g_stg[NSTG-1].a_q[WIDTH-1]
                 ^ g_stg[NSTG-1].b_q[WIDTH-1];

    assign out_valid = g_stg[NSTG-1].v_q;
    assign sum       = g_stg[NSTG-1].s_q;
    assign co        = g_stg[NSTG-1].c_q;
    assign ovf       = c_msb ^ g_stg[NSTG-1].c_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder at WIDTH=16, GROUP=4.
// Scoreboard queue filled on input transfer, drained on output transfer.
module tb_pipe_cla_adder;

    localparam int W = 16;
    localparam int G = 4;
    localparam int N = W / G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    always #5 clk = ~clk;

    pipe_cla_adder #(
        .WIDTH (W),
        .GROUP (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t q[$];
    res_t dq[$];
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;

    function automatic res_t model(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         ci,
        input logic         s
    );
        logic [W-1:0] be;
        logic [W:0]   f;
        res_t         r;
        be  = s ? ~b : b;
        f   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci ^ s};
        r.s = f[W-1:0];
        r.c = f[W];
        r.v = (a[W-1] == be[W-1]) && (r.s[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: sample mid-cycle; pop before push so same-cycle
    // in/out transfers are both honoured.
    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                tests++;
                assert (q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_out: observed %h expected none",
                           {sum, co, ovf});
                end
                if (q.size() != 0) begin
                    r = q.pop_front();
                    check("result", {sum, co, ovf}, r);
                end
                if (dq.size() != 0) begin
                    r = dq.pop_front();
                    check("directed", {sum, co, ovf}, r);
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(a_in, b_in, c_in, sub));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s);
        int k;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        c_in = ci;
        sub  = s;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while ((q.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        check("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int idx;
        int acc;
        int k;
        int base;
        logic [W-1:0] sa [8];
        logic [W-1:0] sb [8];

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a_in = '0;
        b_in = '0;
        c_in = 1'b0;
        sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Carry out of all-ones, and exact latency.
        dq.push_back('{s: 16'h0000, c: 1'b1, v: 1'b0});
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int i = 1; i <= N; i++) begin
            check($sformatf("latency_c%0d", i), 32'(out_valid),
                  32'(i == N));
            if (i < N) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Signed overflow both directions and borrow-in.
        dq.push_back('{s: 16'h8000, c: 1'b0, v: 1'b1});
        dq.push_back('{s: 16'h7FFF, c: 1'b1, v: 1'b1});
        dq.push_back('{s: 16'hFFFE, c: 1'b0, v: 1'b0});
        dq.push_back('{s: 16'hFFFD, c: 1'b0, v: 1'b0});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        drain();
        check("directed_used", 32'(dq.size()), 32'd0);

        // Back-to-back stream with a 3-cycle downstream stall.
        for (int i = 0; i < 8; i++) begin
            sa[i] = W'($urandom);
            sb[i] = W'($urandom);
        end
        base = n_out;
        idx = 0;
        for (int c = 0; c < 30 && (idx < 8 || c < 12); c++) begin
            out_ready = !(c >= 6 && c <= 8);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a_in = sa[idx];
                b_in = sb[idx];
                c_in = idx[0];
                sub  = idx[1];
            end
            @(negedge clk);
            check($sformatf("stall_in_ready_c%0d", c), 32'(in_ready),
                  32'(!(c >= 6 && c <= 8)));
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stream_accepted", 32'(idx), 32'd8);
        drain();
        check("stream_outputs", 32'(n_out - base), 32'd8);

        // Reset with three operations in flight.
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h2345, 16'h0101, 1'b1, 1'b0);
        send(16'h3456, 16'h0011, 1'b0, 1'b1);
        base = n_out;
        rst = 1'b1;
        in_valid = 1'b1;
        a_in = 16'hAAAA;
        b_in = 16'h5555;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (2 * N) @(posedge clk);
        #1;
        check("flush_no_output", 32'(n_out - base), 32'd0);
        send(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        drain();
        check("post_flush_output", 32'(n_out - base), 32'd1);

        // Random traffic with random handshakes on both sides.
        acc = 0;
        k = 0;
        while (acc < 10000 && k < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a_in = W'($urandom);
            b_in = W'($urandom);
            c_in = 1'($urandom);
            sub  = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        check("random_accepted", 32'(acc), 32'd10000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
